// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: encodings, stage record and hazard helpers for pipe_ctrl.
// Multiply/divide fields exist only when MULDIV_EN is defined.
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;

`ifdef MULDIV_EN
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;
  localparam logic [2:0] MD_MFHI  = 3'd6;
  localparam logic [2:0] MD_MFLO  = 3'd7;

  localparam logic [1:0] GRF_HILO = 2'b11;
`endif

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [1:0] PC_NEXT = 2'b00;
  localparam logic [1:0] PC_BEQ  = 2'b01;
  localparam logic [1:0] PC_JAL  = 2'b10;
  localparam logic [1:0] PC_JR   = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;

  localparam logic [1:0] GRF_ALU = 2'b00;
  localparam logic [1:0] GRF_DM  = 2'b01;
  localparam logic [1:0] GRF_PC8 = 2'b10;

  localparam logic [1:0] FWD_D_M = 2'b01;
  localparam logic [1:0] FWD_D_E = 2'b10;
  localparam logic [1:0] FWD_E_W = 2'b01;
  localparam logic [1:0] FWD_E_M = 2'b10;

  // TUSE_NA exceeds every Tnew, so an unused source never stalls
  localparam logic [1:0] TUSE_0  = 2'd0;
  localparam logic [1:0] TUSE_1  = 2'd1;
  localparam logic [1:0] TUSE_2  = 2'd2;
  localparam logic [1:0] TUSE_NA = 2'd3;

  typedef struct packed {
`ifdef MULDIV_EN
    logic       md_en;
    logic       md_start;
    logic [2:0] md_op;
`endif
    logic [1:0] alu_op;
    logic       alu_src;
    logic       dm_we;
    logic       grf_we;
    logic [1:0] grf_data;
    logic [4:0] a3;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] tnew;
  } ctrl_t;

  function automatic logic hits(
    input logic [4:0] src,
    input ctrl_t      s
  );
    return s.grf_we && (src != 5'd0) && (src == s.a3);
  endfunction

  function automatic logic [1:0] tnew_dec(
    input logic [1:0] t
  );
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input ctrl_t      yng,
    input ctrl_t      old,
    input logic [1:0] sel_yng,
    input logic [1:0] sel_old
  );
    if (hits(src, yng))
      return (yng.tnew == 2'd0) ? sel_yng : 2'b00;
    if (hits(src, old))
      return (old.tnew == 2'd0) ? sel_old : 2'b00;
    return 2'b00;
  endfunction

endpackage

// File: rtl/pipe_ctrl_decode.sv
// pipe_ctrl_decode: instruction to stage record, D-stage selects and Tuse.
// MULDIV_EN adds the multiply/divide opcodes.
module pipe_ctrl_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic [1:0]  ext_op,
  output logic [1:0]  pc_op,
  output logic [1:0]  tuse_rs,
  output logic [1:0]  tuse_rt
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [4:0] a3;
  logic [1:0] tnew;
  logic       r_type;
  logic       is_add;
  logic       is_sub;
  logic       is_jr;
  logic       is_ori;
  logic       is_lw;
  logic       is_sw;
  logic       is_beq;
  logic       is_lui;
  logic       is_jal;
  logic       unused_shamt;

  assign op     = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign fn     = instr[5:0];
  assign r_type = (op == OP_RTYPE);
  assign is_add = r_type && (fn == FN_ADD);
  assign is_sub = r_type && (fn == FN_SUB);
  assign is_jr  = r_type && (fn == FN_JR);
  assign is_ori = (op == OP_ORI);
  assign is_lw  = (op == OP_LW);
  assign is_sw  = (op == OP_SW);
  assign is_beq = (op == OP_BEQ);
  assign is_lui = (op == OP_LUI);
  assign is_jal = (op == OP_JAL);

  assign unused_shamt = ^instr[10:6];

`ifdef MULDIV_EN
  logic       is_md;
  logic       is_mt;
  logic       is_mf;
  logic [2:0] md_op;

  assign is_md = r_type &&
    (fn inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
  assign is_mt = r_type && (fn inside {FN_MTHI, FN_MTLO});
  assign is_mf = r_type && (fn inside {FN_MFHI, FN_MFLO});

  always_comb begin
    unique case (fn)
      FN_MULTU: md_op = MD_MULTU;
      FN_DIV:   md_op = MD_DIV;
      FN_DIVU:  md_op = MD_DIVU;
      FN_MTHI:  md_op = MD_MTHI;
      FN_MTLO:  md_op = MD_MTLO;
      FN_MFHI:  md_op = MD_MFHI;
      FN_MFLO:  md_op = MD_MFLO;
      default:  md_op = MD_MULT;
    endcase
  end
`endif

  always_comb begin
    ctrl    = '0;
    ext_op  = EXT_ZERO;
    pc_op   = PC_NEXT;
    tuse_rs = TUSE_NA;
    tuse_rt = TUSE_NA;
    a3      = 5'd0;
    tnew    = 2'd0;
    unique case (1'b1)
      is_add, is_sub: begin
        ctrl.alu_op = is_sub ? ALU_SUB : ALU_ADD;
        a3      = rd;
        tnew    = 2'd1;
        tuse_rs = TUSE_1;
        tuse_rt = TUSE_1;
      end
      is_ori: begin
        ctrl.alu_op  = ALU_OR;
        ctrl.alu_src = 1'b1;
        a3      = rt;
        tnew    = 2'd1;
        tuse_rs = TUSE_1;
      end
      is_lui: begin
        ctrl.alu_op  = ALU_OR;
        ctrl.alu_src = 1'b1;
        ext_op  = EXT_LUI;
        a3      = rt;
        tnew    = 2'd1;
        tuse_rs = TUSE_1;
      end
      is_lw: begin
        ctrl.alu_src  = 1'b1;
        ctrl.grf_data = GRF_DM;
        ext_op  = EXT_SIGN;
        a3      = rt;
        tnew    = 2'd2;
        tuse_rs = TUSE_1;
      end
      is_sw: begin
        ctrl.alu_src = 1'b1;
        ctrl.dm_we   = 1'b1;
        ext_op  = EXT_SIGN;
        tuse_rs = TUSE_1;
        tuse_rt = TUSE_2;
      end
      is_beq: begin
        ext_op  = EXT_SIGN;
        pc_op   = PC_BEQ;
        tuse_rs = TUSE_0;
        tuse_rt = TUSE_0;
      end
      is_jal: begin
        ctrl.grf_data = GRF_PC8;
        pc_op = PC_JAL;
        a3    = 5'd31;
        tnew  = 2'd0;
      end
      is_jr: begin
        pc_op   = PC_JR;
        tuse_rs = TUSE_0;
      end
`ifdef MULDIV_EN
      is_md: begin
        ctrl.md_en    = 1'b1;
        ctrl.md_start = 1'b1;
        ctrl.md_op    = md_op;
        tuse_rs = TUSE_1;
        tuse_rt = TUSE_1;
      end
      is_mt: begin
        ctrl.md_en = 1'b1;
        ctrl.md_op = md_op;
        tuse_rs = TUSE_1;
      end
      is_mf: begin
        ctrl.md_en    = 1'b1;
        ctrl.md_op    = md_op;
        ctrl.grf_data = GRF_HILO;
        a3   = rd;
        tnew = 2'd1;
      end
`endif
      default: ;
    endcase
    ctrl.a3     = a3;
    ctrl.grf_we = (a3 != 5'd0);
    ctrl.tnew   = tnew;
    ctrl.rs     = (tuse_rs == TUSE_NA) ? 5'd0 : rs;
    ctrl.rt     = (tuse_rt == TUSE_NA) ? 5'd0 : rt;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: five-stage control pipeline with Tuse/Tnew stall and forwarding.
// Define MULDIV_EN to add multiply/divide sequencing and its ports.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_D,
  output logic        stall,
  output logic [1:0]  EXT_op_D,
  output logic [1:0]  PC_op_D,
  output logic [1:0]  fwd_rs_D,
  output logic [1:0]  fwd_rt_D,
  output logic [1:0]  ALU_op_E,
  output logic        ALU_src_E,
  output logic [1:0]  fwd_rs_E,
  output logic [1:0]  fwd_rt_E,
  output logic        DM_WE_M,
  output logic        fwd_rt_M,
  output logic        GRF_WE_W,
  output logic [4:0]  GRF_A3_W,
`ifdef MULDIV_EN
  output logic        md_start_E,
  output logic [2:0]  md_op_E,
  output logic        md_busy,
`endif
  output logic [1:0]  GRF_data_W
);

  ctrl_t      d_c;
  ctrl_t      e_d;
  ctrl_t      e_q;
  ctrl_t      m_d;
  ctrl_t      m_q;
  ctrl_t      w_d;
  ctrl_t      w_q;
  logic [1:0] tuse_rs;
  logic [1:0] tuse_rt;
  logic       hz_stall;
  logic       md_stall;
  logic       unused_w;

  pipe_ctrl_decode u_dec (
    .instr   (instr_D),
    .ctrl    (d_c),
    .ext_op  (EXT_op_D),
    .pc_op   (PC_op_D),
    .tuse_rs (tuse_rs),
    .tuse_rt (tuse_rt)
  );

  always_comb begin
    hz_stall =
      (hits(d_c.rs, e_q) && (tuse_rs < e_q.tnew)) ||
      (hits(d_c.rs, m_q) && (tuse_rs < m_q.tnew)) ||
      (hits(d_c.rt, e_q) && (tuse_rt < e_q.tnew)) ||
      (hits(d_c.rt, m_q) && (tuse_rt < m_q.tnew));
  end

`ifdef MULDIV_EN
  localparam int MD_MAX =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MD_MAX + 1);

  logic [CW-1:0] md_cnt_d;
  logic [CW-1:0] md_cnt_q;

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (e_q.md_start) begin
      if (e_q.md_op inside {MD_DIV, MD_DIVU})
        md_cnt_d = CW'(DIV_CYCLES);
      else
        md_cnt_d = CW'(MULT_CYCLES);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CW'(1);
    end
  end

  assign md_busy    = (md_cnt_q != '0);
  assign md_start_E = e_q.md_start;
  assign md_op_E    = e_q.md_op;
  // HI/LO is shared, so every muldiv op waits for the unit to drain
  assign md_stall   = d_c.md_en && (md_busy || e_q.md_start);
`else
  logic unused_params;
  assign unused_params = ^{32'(MULT_CYCLES), 32'(DIV_CYCLES)};
  assign md_stall = 1'b0;
`endif

  assign stall = hz_stall || md_stall;

  always_comb begin
    e_d      = stall ? '0 : d_c;
    m_d      = e_q;
    m_d.tnew = tnew_dec(e_q.tnew);
    w_d      = m_q;
    w_d.tnew = tnew_dec(m_q.tnew);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
`ifdef MULDIV_EN
      md_cnt_q <= '0;
`endif
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
`ifdef MULDIV_EN
      md_cnt_q <= md_cnt_d;
`endif
    end
  end

  always_comb begin
    fwd_rs_D = fwd_sel(d_c.rs, e_q, m_q, FWD_D_E, FWD_D_M);
    fwd_rt_D = fwd_sel(d_c.rt, e_q, m_q, FWD_D_E, FWD_D_M);
    fwd_rs_E = fwd_sel(e_q.rs, m_q, w_q, FWD_E_M, FWD_E_W);
    fwd_rt_E = fwd_sel(e_q.rt, m_q, w_q, FWD_E_M, FWD_E_W);
    fwd_rt_M = m_q.dm_we && hits(m_q.rt, w_q) &&
               (w_q.tnew == 2'd0);
  end

  assign ALU_op_E   = e_q.alu_op;
  assign ALU_src_E  = e_q.alu_src;
  assign DM_WE_M    = m_q.dm_we;
  assign GRF_WE_W   = w_q.grf_we;
  assign GRF_A3_W   = w_q.a3;
  assign GRF_data_W = w_q.grf_data;
  assign unused_w   = ^w_q;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipelined control and hazard unit for the five-stage MIPS core. It decodes the instruction held in the F/D register and carries per-instruction control fields through internal E, M and W stage registers. From per-stage Tuse/Tnew bookkeeping it generates forwarding selects and the stall signal. It sits beside the datapath, replaces the single-cycle decoder, and optionally sequences a multi-cycle multiply/divide unit.

## Interface
Parameters:
- MULT_CYCLES, 5: busy cycles after a mult/multu enters E.
- DIV_CYCLES, 10: busy cycles after a div/divu enters E.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; all stage registers clear to nop.
- instr_D  in  32  instruction in the F/D register.
- stall  out  1  freezes PC and the F/D register; a bubble is injected into E.
- EXT_op_D  out  2  00 zero-extend, 01 sign-extend, 10 lui (imm<<16).
- PC_op_D  out  2  00 PC+4, 01 beq, 10 jal, 11 jr.
- fwd_rs_D, fwd_rt_D  out  2 each  compare/jr source: 00 GRF read, 01 M result, 10 E result (PC+8 only).
- ALU_op_E  out  2  00 add, 01 sub, 10 or.
- ALU_src_E  out  1  0 rt, 1 extended immediate.
- fwd_rs_E, fwd_rt_E  out  2 each  00 pipeline value, 01 W result, 10 M result.
- DM_WE_M  out  1  data-memory write enable.
- fwd_rt_M  out  1  sw store data: 0 pipeline value, 1 W result.
- GRF_WE_W  out  1  register-file write enable.
- GRF_A3_W  out  5  write address; 0 whenever GRF_WE_W is 0.
- GRF_data_W  out  2  00 ALU, 01 DM, 10 PC+8, 11 HI/LO (MULDIV_EN only).
- md_start_E, md_op_E[2:0], md_busy  out  present only with MULDIV_EN.

## Operation
- Decoded set: add, sub, ori, lw, sw, beq, lui, jal, jr, sll with rd=0 (nop). Unknown opcodes decode as nop: no writes, PC+4.
- Destination: rd for add/sub; rt for ori/lw/lui; 31 for jal; otherwise 0. A destination of 0 never writes and never matches a hazard.
- Tuse for rs/rt: beq 0/0; jr 0/–; add/sub 1/1; ori/lw/lui 1/–; sw 1/2.
- Tnew entering E: jal 0; add/sub/ori/lui 1; lw 2. Tnew decrements saturating at 0 on each stage advance.
- Stall condition: any D source with Tuse < Tnew of a matching destination in E or M.
- Forwarding: select the youngest matching stage whose Tnew is 0. Priority is E > M > W for D consumers and M > W for E consumers.
- Stall response: E loads a bubble with all fields 0. M and W still advance.

## Timing
- D outputs and stall are combinational from instr_D and the stage registers.
- E, M and W outputs are registered with one-cycle advance per stage. An instruction's W controls appear 3 cycles after it leaves D.
- After reset deassertion all registered outputs are 0 and stall is 0 until instr_D creates a hazard.
- Reset mid-stall: the bubble and pending state are discarded and all stages become nop on the asynchronous edge.
- A lw followed by a dependent beq stalls 2 cycles. A lw followed by a dependent add stalls 1 cycle. A lw followed by a dependent sw rt does not stall; the store data forwards from W.

## Configuration
- MULDIV_EN defined:
  - Adds mult, multu, div, divu, mthi, mtlo, mfhi and mflo.
  - md_start_E pulses for one cycle as mult/div enters E.
  - The busy counter loads MULT_CYCLES or DIV_CYCLES and decrements to 0; md_busy = (counter != 0).
  - Any muldiv instruction in D stalls while md_busy or md_start_E is set.
  - mfhi/mflo enter E with Tnew 1 and GRF_data 11.
  - Reset clears the counter.
- MULDIV_EN undefined: the muldiv ports, counter and decode are absent, and those opcodes decode as nop.

## Structure
- Package pipe_ctrl_pkg holds:
  - opcode/funct constants;
  - EXT/ALU/PC/GRF_data encodings;
  - a packed ctrl_t stage record (controls, A3, Tnew);
  - Tuse constants.
- Sub-module pipe_ctrl_decode: combinational instr → ctrl_t plus Tuse. It is instantiated once, on D.

## Test plan
- Reset with instr_D=add $3,$1,$2 held: all outputs 0 during reset; the cycle after release, ALU_op_E=00 and GRF_A3_W=3 appear three cycles later.
- lw $5,0($1) then beq $5,$0: stall=1 for exactly 2 cycles, then fwd_rs_D=00.
- ori $4,$0,7 then add $6,$4,$4: no stall; fwd_rs_E=fwd_rt_E=10.
- jal then jr $31: no stall; fwd_rs_D=10 in the jr D cycle.
- Write to $0 followed by a reader of $0: no stall, all selects 00.
- MULDIV_EN with mult then mflo: md_start_E=1 once; stall asserted for MULT_CYCLES+1 cycles; GRF_data_W=11 on mflo retirement.
